counter_seq_ctrl: RTL and testbench
===================================

Name: counter_seq_ctrl

Overview:
Sequencing controller for a WIDTH-bit synchronous up-counter datapath. It accepts start/stop/pause commands over a valid/ready interface and runs the count to a programmable terminal value. It supports one-shot or periodic (auto-restart) operation and raises a level interrupt on terminal count, held until acknowledged. It sits between a register/command front end and the counter datapath, and owns the count register itself.

Parameters:
WIDTH, 4, counter and limit width in bits (legal range 2..16)

Ports:
clk  input  1  single clock, all state changes on posedge
rst  input  1  asynchronous reset, active-low (rst=0 resets immediately, independent of clk)
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command this cycle
cmd_op  input  2  00 NOP, 01 START, 10 STOP, 11 PAUSE (toggle pause/resume)
cmd_limit  input  WIDTH  terminal count; sampled only on accepted START
cmd_periodic  input  1  1 = auto-restart at terminal count; sampled only on accepted START
count_en  input  1  count enable (tick); counting occurs only when high
count  output  WIDTH  current count value
busy  output  1  high in RUN or PAUSE
tc_pulse  output  1  one-cycle pulse on terminal count
irq  output  1  interrupt, level, set on terminal count
irq_ack  input  1  clears irq
overrun  output  1  sticky: terminal count occurred while irq already set

Behaviour:
- Reset (rst=0, async): state IDLE; count=0, limit=0, periodic=0, irq=0, overrun=0, tc_pulse=0, busy=0. Reset mid-count aborts with no tc_pulse.
- States: IDLE, RUN, PAUSE, DONE. busy = (RUN|PAUSE), registered with state.
- Accept: a command is accepted when cmd_valid & cmd_ready at a posedge. cmd_ready = ~irq, combinational from the irq register. NOP is accepted and has no effect.
- START, from any state: limit<=cmd_limit, periodic<=cmd_periodic, count<=0, overrun<=0, next state RUN. Counting begins at the next posedge with count_en=1. count_en in the accept cycle is ignored.
- STOP: in RUN, PAUSE or DONE, go to IDLE with count<=0. In IDLE it is a no-op.
- PAUSE: RUN->PAUSE and PAUSE->RUN, with count held. In IDLE or DONE it is a no-op.
- RUN, count_en=1, count!=limit: count<=count+1.
- RUN, count_en=1, count==limit (terminal count): tc_pulse=1 for the following cycle (registered) and irq<=1.
  - If irq is already 1, overrun<=1.
  - periodic=1: count<=0 and stay in RUN.
  - periodic=0: count holds at limit and state goes to DONE.
- RUN, count_en=0: hold.
- PAUSE, IDLE, DONE: count_en is ignored and count holds.
- limit=0: terminal count on every enabled cycle. Periodic mode then gives tc_pulse on each count_en cycle.
- Width: count never exceeds limit, so no wrap past 2^WIDTH-1 occurs. A limit of all-ones gives a period of 2^WIDTH enabled ticks.
- irq: set on terminal count, cleared when irq_ack=1. If set and clear occur in the same cycle, set wins. irq_ack while irq=0 has no effect.
- Command blocking: commands are blocked while irq=1, but the periodic count continues. overrun records any missed events.
- No command can coincide with terminal count handling in a way that conflicts: while irq=1 no command is accepted. When irq=0, an accepted START/STOP/PAUSE takes priority over the count update in that cycle, and no tc occurs in that cycle.
- tc_pulse is exactly one cycle wide, including back-to-back terminal counts (limit=0 gives a continuous high).

Test Plan:
- Reset: rst=0 mid-RUN at count=3 -> immediately count=0, busy=0, irq=0, cmd_ready=1, with no clk edge required.
- One-shot: START limit=5, periodic=0, count_en=1 continuous.
  - count steps 0..5.
  - tc_pulse high 1 cycle after count reaches 5 and the next enable.
  - state DONE with count held at 5, irq=1, cmd_ready=0.
  - irq_ack -> irq=0, cmd_ready=1.
- Periodic without ack: START limit=2, periodic=1.
  - tc_pulse every 3 enabled cycles.
  - second tc without ack -> overrun=1.
  - new START after ack -> overrun=0.
- Pause and enable gating: START limit=9, run to count=4, PAUSE -> count holds at 4 for 10 cycles with count_en=1. PAUSE again -> resumes 5,6,... With count_en toggling 1/0, count advances only on enabled cycles.
- Boundaries:
  - limit=0 periodic -> tc_pulse continuously high with count_en=1.
  - limit=15 (WIDTH=4) -> 16-tick period with no wrap glitch.
  - irq_ack coincident with a new tc -> irq stays 1.
- Command priority: STOP issued in the same cycle count==limit with count_en=1 (irq=0) -> IDLE, count=0, no tc_pulse, irq stays 0. STOP in IDLE -> no change.

Source files
------------

// File: rtl/counter_seq_ctrl.sv
// Sequencing controller owning a WIDTH-bit up-counter: start/stop/pause commands, terminal-count irq.
// Latency: command takes effect at the accepting posedge; tc_pulse/irq appear one cycle after the terminal tick.
// Backpressure: cmd_ready drops while irq is pending; counting continues regardless of command blocking.
module counter_seq_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_limit,
    input  logic             cmd_periodic,
    input  logic             count_en,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc_pulse,
    output logic             irq,
    input  logic             irq_ack,
    output logic             overrun
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    localparam logic [1:0] OP_START = 2'b01;
    localparam logic [1:0] OP_STOP  = 2'b10;
    localparam logic [1:0] OP_PAUSE = 2'b11;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] limit_q;
    logic             periodic_q;
    logic             irq_q;
    logic             overrun_q;
    logic             tc_pulse_q;
    logic             busy_q;
    logic             cmd_accept;

    // Commands are refused only while an interrupt is outstanding.
    assign cmd_ready  = ~irq_q;
    assign cmd_accept = cmd_valid & cmd_ready;

    assign count    = count_q;
    assign busy     = busy_q;
    assign tc_pulse = tc_pulse_q;
    assign irq      = irq_q;
    assign overrun  = overrun_q;

    // Sequencer: an accepted START/STOP/PAUSE pre-empts the count update in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            limit_q    <= '0;
            periodic_q <= 1'b0;
            irq_q      <= 1'b0;
            overrun_q  <= 1'b0;
            tc_pulse_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            tc_pulse_q <= 1'b0;
            // Ack clears; a terminal count below re-sets it, so set wins.
            if (irq_ack) begin
                irq_q <= 1'b0;
            end

            if (cmd_accept && cmd_op == OP_START) begin
                limit_q    <= cmd_limit;
                periodic_q <= cmd_periodic;
                count_q    <= '0;
                overrun_q  <= 1'b0;
                state_q    <= S_RUN;
                busy_q     <= 1'b1;
            end else if (cmd_accept && cmd_op == OP_STOP) begin
                if (state_q != S_IDLE) begin
                    state_q <= S_IDLE;
                    count_q <= '0;
                    busy_q  <= 1'b0;
                end
            end else if (cmd_accept && cmd_op == OP_PAUSE) begin
                // Toggle only between RUN and PAUSE; busy stays high in both.
                if (state_q == S_RUN) begin
                    state_q <= S_PAUSE;
                end else if (state_q == S_PAUSE) begin
                    state_q <= S_RUN;
                end
            end else if (state_q == S_RUN && count_en) begin
                if (count_q == limit_q) begin
                    tc_pulse_q <= 1'b1;
                    irq_q      <= 1'b1;
                    if (irq_q) begin
                        overrun_q <= 1'b1;
                    end
                    if (periodic_q) begin
                        count_q <= '0;
                    end else begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                    end
                end else begin
                    count_q <= count_q + ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Self-checking bench for counter_seq_ctrl: directed scenarios then randomized commands.
// Reference model tracks the controller at the command/tick level and is compared every cycle.
// Inputs change #1 after posedge; outputs are sampled #1 after posedge.
module tb_counter_seq_ctrl;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'b00;
    logic [WIDTH-1:0] cmd_limit = '0;
    logic             cmd_periodic = 1'b0;
    logic             count_en = 1'b0;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             tc_pulse;
    logic             irq;
    logic             irq_ack = 1'b0;
    logic             overrun;

    int tests = 0;
    int fails = 0;

    // Model: mode 0=idle 1=running 2=paused 3=finished
    int m_mode, m_count, m_limit, m_per, m_irq, m_ovr, m_tc;

    counter_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_limit(cmd_limit), .cmd_periodic(cmd_periodic),
        .count_en(count_en), .count(count), .busy(busy), .tc_pulse(tc_pulse),
        .irq(irq), .irq_ack(irq_ack), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_count = 0; m_limit = 0; m_per = 0;
        m_irq = 0; m_ovr = 0; m_tc = 0;
    endtask

    // One clock of the specified behaviour, using the inputs held across the edge.
    task automatic model_step();
        int was_irq;
        bit took;
        was_irq = m_irq;
        took    = cmd_valid && (m_irq == 0);
        m_tc    = 0;
        if (irq_ack) m_irq = 0;
        if (took && cmd_op == 2'b01) begin
            m_limit = int'(cmd_limit); m_per = int'(cmd_periodic);
            m_count = 0; m_ovr = 0; m_mode = 1;
        end else if (took && cmd_op == 2'b10) begin
            if (m_mode != 0) begin m_mode = 0; m_count = 0; end
        end else if (took && cmd_op == 2'b11) begin
            if (m_mode == 1 || m_mode == 2) m_mode = 3 - m_mode;
        end else if (m_mode == 1 && count_en) begin
            if (m_count == m_limit) begin
                m_tc = 1; m_irq = 1;
                if (was_irq != 0) m_ovr = 1;
                if (m_per == 0) m_mode = 3;
            end
            // Periodic count runs modulo (limit+1); one-shot saturates at limit.
            m_count = m_per ? (m_count + 1) % (m_limit + 1)
                            : ((m_count < m_limit) ? m_count + 1 : m_limit);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".count"},   int'(count),     m_count);
        chk({tag, ".busy"},    int'(busy),      int'(m_mode == 1 || m_mode == 2));
        chk({tag, ".tc"},      int'(tc_pulse),  m_tc);
        chk({tag, ".irq"},     int'(irq),       m_irq);
        chk({tag, ".ready"},   int'(cmd_ready), int'(m_irq == 0));
        chk({tag, ".overrun"}, int'(overrun),   m_ovr);
    endtask

    task automatic step(input string tag, input bit v, input bit [1:0] op, input int lim,
                        input bit per, input bit en, input bit ack);
        cmd_valid = v; cmd_op = op; cmd_limit = WIDTH'(lim);
        cmd_periodic = per; count_en = en; irq_ack = ack;
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    task automatic idle_step(input string tag, input bit en, input bit ack);
        step(tag, 1'b0, 2'b00, 0, 1'b0, en, ack);
    endtask

    initial begin
        model_reset();
        #3;
        check_all("reset");
        #10 rst = 1'b1;
        @(posedge clk); #1;

        // Asynchronous reset mid-run at count 3
        step("rs_start", 1, 2'b01, 9, 0, 1, 0);
        for (int i = 0; i < 3; i++) idle_step("rs_run", 1, 0);
        chk("rs_pre_count", int'(count), 3);
        #2 rst = 1'b0;
        #1 model_reset();
        check_all("async_rst");
        #2 rst = 1'b1;
        @(posedge clk); #1;

        // One-shot to 5
        step("os_start", 1, 2'b01, 5, 0, 1, 0);
        for (int i = 0; i < 7; i++) idle_step("os_run", 1, 0);
        chk("os_hold5", int'(count), 5);
        chk("os_irq", int'(irq), 1);
        chk("os_blocked", int'(cmd_ready), 0);
        idle_step("os_ack", 0, 1);
        chk("os_ready", int'(cmd_ready), 1);

        // Periodic limit 2 without ack -> overrun
        step("pd_start", 1, 2'b01, 2, 1, 1, 0);
        for (int i = 0; i < 7; i++) idle_step("pd_run", 1, 0);
        chk("pd_overrun", int'(overrun), 1);
        idle_step("pd_ack", 0, 1);
        step("pd_restart", 1, 2'b01, 2, 1, 0, 0);
        chk("pd_ovr_clr", int'(overrun), 0);

        // Pause and enable gating
        step("pz_start", 1, 2'b01, 9, 0, 0, 0);
        for (int i = 0; i < 4; i++) idle_step("pz_run", 1, 0);
        step("pz_pause", 1, 2'b11, 0, 0, 1, 0);
        for (int i = 0; i < 10; i++) idle_step("pz_hold", 1, 0);
        chk("pz_held4", int'(count), 4);
        step("pz_resume", 1, 2'b11, 0, 0, 1, 0);
        for (int i = 0; i < 6; i++) idle_step("pz_gate", i[0] == 1'b0, 0);
        chk("pz_gated7", int'(count), 7);
        step("pz_stop", 1, 2'b10, 0, 0, 0, 0);

        // limit 0 periodic, with ack coincident with each tc
        step("l0_start", 1, 2'b01, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) idle_step("l0_run", 1, 0);
        for (int i = 0; i < 3; i++) idle_step("l0_ackcoin", 1, 1);
        chk("l0_irq_kept", int'(irq), 1);
        idle_step("l0_ack", 0, 1);
        step("l0_stop", 1, 2'b10, 0, 0, 0, 0);

        // limit 15: 16-tick period, no wrap glitch
        step("l15_start", 1, 2'b01, 15, 1, 0, 0);
        for (int i = 0; i < 34; i++) idle_step("l15_run", 1, (i % 5) == 0);
        idle_step("l15_ack", 0, 1);
        step("l15_stop", 1, 2'b10, 0, 0, 0, 0);

        // STOP coinciding with terminal count wins; STOP in idle is a no-op
        step("pr_start", 1, 2'b01, 3, 0, 0, 0);
        for (int i = 0; i < 3; i++) idle_step("pr_run", 1, 0);
        step("pr_stop_tc", 1, 2'b10, 0, 0, 1, 0);
        chk("pr_no_irq", int'(irq), 0);
        step("pr_stop_idle", 1, 2'b10, 0, 0, 1, 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step("rnd",
                 $urandom_range(0, 3) == 0,
                 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 4) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
